// File: rtl/rv_isa_pkg.sv
// RV32I definitions shared by the main decoder and the in-system instruction encoder.
// Holds instruction classes, base opcodes, immediate formats and an immediate-fit helper.
package rv_isa_pkg;

  typedef enum logic [2:0] {
    OC_LW  = 3'd0,
    OC_SW  = 3'd1,
    OC_R   = 3'd2,
    OC_B   = 3'd3,
    OC_I   = 3'd4,
    OC_JAL = 3'd5
  } op_class_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_R
  } imm_fmt_e;

  // True when v is representable as a signed value of the given bit count.
  function automatic logic fits_signed(input logic [31:0] v, input int bits);
    logic signed [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == 32'sd0) || (s == -32'sd1);
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: instruction fields of one class -> 32-bit RV32I word.
// Optional immediate range checking is enabled by defining ENCODER_RANGE_CHECK_EN.
module instr_field_packer
  import rv_isa_pkg::*;
(
  input  logic [2:0]  op_class,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        class_ok,
  output logic        range_ok
);

  op_class_e cls;
  imm_fmt_e  fmt;

  assign cls = op_class_e'(op_class);

  always_comb begin
    word     = '0;
    class_ok = 1'b1;
    fmt      = FMT_R;
    case (cls)
      OC_LW: begin
        fmt  = FMT_I;
        word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      end
      OC_SW: begin
        fmt  = FMT_S;
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      end
      OC_R: begin
        fmt  = FMT_R;
        word = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OPC_OP};
      end
      OC_B: begin
        fmt  = FMT_B;
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
      end
      OC_I: begin
        fmt = FMT_I;
        // slli/srli/srai carry a shamt with funct7 in the upper immediate bits
        if (funct3 == 3'b001 || funct3 == 3'b101)
          word = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, OPC_OP_IMM};
        else
          word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
      end
      OC_JAL: begin
        fmt  = FMT_J;
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      default: class_ok = 1'b0;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  always_comb begin
    range_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: range_ok = fits_signed(imm, 12);
      FMT_B:        range_ok = fits_signed(imm, 13) && !imm[0];
      FMT_J:        range_ok = fits_signed(imm, 21) && !imm[0];
      default:      range_ok = 1'b1;
    endcase
  end
`else
  logic unused_imm;
  assign range_ok   = 1'b1;
  assign unused_imm = ^{imm[31:21], imm[0], fmt};
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field bundles into RV32I words and streams them into instruction memory.
// Build option ENCODER_RANGE_CHECK_EN (in instr_field_packer) rejects out-of-range immediates.
module instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op_class,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   CAP  = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FULL} ld_state_e;

  ld_state_e             state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [31:0]           word;
  logic                  class_ok, range_ok;
  logic                  xfer, legal;
  logic [ADDR_WIDTH:0]   count_nxt;

  instr_field_packer u_packer (
    .op_class (op_class),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .word     (word),
    .class_ok (class_ok),
    .range_ok (range_ok)
  );

  assign in_ready  = (state != ST_FULL) && !clear;
  assign xfer      = in_valid && in_ready;
  assign legal     = class_ok && range_ok;
  assign count_nxt = count + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= BASE;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      // A write strobed this cycle has already reached memory, so clear only rewinds
      if (clear) begin
        state    <= ST_IDLE;
        wr_ptr   <= BASE;
        mem_addr <= BASE;
        count    <= '0;
        full     <= 1'b0;
        err      <= 1'b0;
      end else if (xfer) begin
        if (legal) begin
          mem_we    <= 1'b1;
          mem_wdata <= word;
          mem_addr  <= wr_ptr;
          wr_ptr    <= wr_ptr + 1'b1;
          count     <= count_nxt;
          if (count_nxt == CAP) begin
            state <= ST_FULL;
            full  <= 1'b1;
          end else begin
            state <= ST_ACTIVE;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized scoreboard bench for instr_encoder_loader (4-word memory to exercise FULL/clear).
module tb_instr_encoder_loader;

  localparam int AW  = 2;
  localparam int CAP = 4;

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, in_ready;
  logic [2:0]    op_class, funct3;
  logic          funct7b5;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full, err;

  instr_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .funct3(funct3), .funct7b5(funct7b5),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cnt;
    bit          full;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_addr = 0, m_count = 0;
  bit   m_full = 0, m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference encoding built from the field-placement tables with shifts and masks
  function automatic logic [31:0] ref_enc(input logic [31:0] cls, input logic [31:0] f3,
      input logic [31:0] f7, input logic [31:0] rdv, input logic [31:0] r1,
      input logic [31:0] r2, input logic [31:0] im);
    logic [31:0] common;
    common = (r1 << 15) | (f3 << 12);
    case (cls)
      0: return ((im & 32'hFFF) << 20) | common | (rdv << 7) | 32'h03;
      1: return (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | common | ((im & 32'h1F) << 7) | 32'h23;
      2: return (f7 << 30) | (r2 << 20) | common | (rdv << 7) | 32'h33;
      3: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20) | common
                | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'h63;
      4: if (f3 == 1 || f3 == 5)
           return (f7 << 30) | ((im & 32'h1F) << 20) | common | (rdv << 7) | 32'h13;
         else
           return ((im & 32'hFFF) << 20) | common | (rdv << 7) | 32'h13;
      5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 32'h1) << 20)
                | (((im >> 12) & 32'hFF) << 12) | (rdv << 7) | 32'h6F;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [31:0] cls, input logic [31:0] im);
    int s;
    s = $signed(im);
    if (cls > 5) return 0;
`ifdef ENCODER_RANGE_CHECK_EN
    case (cls)
      0, 1, 4: return (s >= -2048) && (s <= 2047);
      3:       return (s >= -4096) && (s <= 4095) && (im[0] == 1'b0);
      5:       return (s >= -1048576) && (s <= 1048575) && (im[0] == 1'b0);
      default: return 1;
    endcase
`else
    return (s == s);
`endif
  endfunction

  // One clock of stimulus; updates the model and queues the expected write
  task automatic cyc(input bit v, input logic [31:0] cls, input logic [31:0] f3, input logic [31:0] f7,
      input logic [31:0] rdv, input logic [31:0] r1, input logic [31:0] r2,
      input logic [31:0] im, input bit clr);
    exp_t e;
    in_valid = v;   clear = clr;
    op_class = cls[2:0]; funct3 = f3[2:0]; funct7b5 = f7[0];
    rd = rdv[4:0];  rs1 = r1[4:0]; rs2 = r2[4:0]; imm = im;
    @(negedge clk);
    check("in_ready", {31'b0, in_ready}, {31'b0, (!m_full && !clr)});
    if (clr) begin
      m_addr = 0; m_count = 0; m_full = 0; m_err = 0;
    end else if (v && !m_full) begin
      if (ref_legal(cls, im)) begin
        e.addr = m_addr;
        e.data = ref_enc(cls, f3 & 32'h7, f7 & 32'h1, rdv & 32'h1F, r1 & 32'h1F, r2 & 32'h1F, im);
        e.cnt  = m_count + 1;
        e.full = (m_count + 1 == CAP);
        sbq.push_back(e);
        m_addr  = (m_addr + 1) % CAP;
        m_count = m_count + 1;
        m_full  = (m_count == CAP);
      end else begin
        m_err = 1;
      end
    end
    @(posedge clk); #1;
    check("err", {31'b0, err}, {31'b0, m_err});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_clear();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: every write strobe must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && mem_we === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = sbq.pop_front();
        check("wr_addr",  {30'b0, mem_addr}, e.addr);
        check("wr_data",  mem_wdata, e.data);
        check("wr_count", {29'b0, count}, e.cnt);
        check("wr_full",  {31'b0, full}, {31'b0, e.full});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] edges [12] = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4095, 32'd4096,
                              -32'sd4096, 32'd1048575, 32'd1048576, -32'sd1048576, 32'd7, 32'd0};

  initial begin
    logic [31:0] im;
    bit v, clr;
    int sel;
    rst = 1'b1; clear = 0; in_valid = 0; op_class = 0; funct3 = 0; funct7b5 = 0;
    rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    #12;
    check("rst_we",    {31'b0, mem_we}, 0);
    check("rst_addr",  {30'b0, mem_addr}, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_count", {29'b0, count}, 0);
    check("rst_full",  {31'b0, full}, 0);
    check("rst_err",   {31'b0, err}, 0);
    check("rst_ready", {31'b0, in_ready}, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    cyc(1, 4, 0, 0, 1, 0, 0, 5, 0);                 // addi x1,x0,5
    check("addi_we",   {31'b0, mem_we}, 1);
    check("addi_word", mem_wdata, 32'h00500093);
    do_clear();                                     // clear while the addi write is strobed
    cyc(1, 2, 0, 0, 3, 1, 2, 0, 0);                 // add x3,x1,x2
    check("add_word", mem_wdata, 32'h002081B3);
    cyc(1, 2, 0, 1, 3, 1, 2, 0, 0);                 // sub x3,x1,x2
    check("sub_word",  mem_wdata, 32'h402081B3);
    check("sub_addr",  {30'b0, mem_addr}, 1);
    check("sub_count", {29'b0, count}, 2);
    do_clear();
    cyc(1, 1, 2, 0, 0, 1, 2, 8, 0);                 // sw x2,8(x1)
    check("sw_word", mem_wdata, 32'h0020A423);
    cyc(1, 3, 0, 0, 0, 0, 0, -32'sd4, 0);           // beq x0,x0,-4
    check("beq_word", mem_wdata, 32'hFE000EE3);
    cyc(1, 5, 0, 0, 1, 0, 0, 8, 0);                 // jal x1,8
    check("jal_word", mem_wdata, 32'h008000EF);
    do_clear();

    for (int i = 0; i < 5; i++) cyc(1, 4, 0, 0, i + 1, 0, 0, i, 0);
    check("full_flag",  {31'b0, full}, 1);
    check("full_count", {29'b0, count}, CAP);
    check("full_ready", {31'b0, in_ready}, 0);
    check("full_addr",  {30'b0, mem_addr}, 3);
    do_clear();
    cyc(1, 4, 0, 0, 2, 0, 0, 9, 0);
    check("clear_addr", {30'b0, mem_addr}, 0);

    cyc(1, 6, 0, 0, 1, 2, 3, 4, 0);                 // illegal class
    check("illegal_err",   {31'b0, err}, 1);
    check("illegal_we",    {31'b0, mem_we}, 0);
    check("illegal_count", {29'b0, count}, m_count);
    do_clear();
    cyc(1, 4, 0, 0, 1, 0, 0, 2048, 0);              // immediate one past the 12-bit range
`ifdef ENCODER_RANGE_CHECK_EN
    check("range_err", {31'b0, err}, 1);
`else
    check("range_trunc", mem_wdata, 32'h80000093);
`endif
    do_clear();

    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 2);
      if (sel == 0)      im = $urandom_range(0, 8191) - 4096;
      else if (sel == 1) im = $urandom;
      else               im = edges[$urandom_range(0, 11)];
      clr = ($urandom_range(0, 15) == 0) || (m_full && $urandom_range(0, 2) == 0);
      cyc(v, ($urandom_range(0, 15) < 14) ? $urandom_range(0, 5) : $urandom_range(6, 7),
          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 31), im, clr);
    end

    do_clear();
    cyc(1, 2, 0, 0, 5, 6, 7, 0, 0);
    cyc(1, 4, 0, 0, 5, 6, 7, 3, 0);
    check("pre_rst_we", {31'b0, mem_we}, 1);
    in_valid = 0;
    #1 rst = 1'b1;
    #1;
    check("arst_we",    {31'b0, mem_we}, 0);
    check("arst_addr",  {30'b0, mem_addr}, 0);
    check("arst_count", {29'b0, count}, 0);
    check("arst_full",  {31'b0, full}, 0);
    sbq.delete();
    m_addr = 0; m_count = 0; m_full = 0; m_err = 0;
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    cyc(1, 4, 0, 0, 1, 0, 0, 5, 0);
    check("post_rst_addr", {30'b0, mem_addr}, 0);
    idle();
    idle();
    check("sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
